// File: rtl/argmax_stream_if.sv
// Streaming argmax handshake bundle.
//   i_valid / i_ready / i_logits : input beats, LANES signed logits per beat
//   o_valid / o_ready            : result handshake
//   o_class / o_max_logit        : index and value of the vector maximum
// slave modport is the argmax block, master modport is the surrounding logic.
interface argmax_stream_if #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned NUM_CLASSES = 12,
   parameter int unsigned LANES       = 4
);
   localparam int unsigned CLS_W = ($clog2(NUM_CLASSES) > 1) ? $clog2(NUM_CLASSES) : 1;

   logic                          i_valid;
   logic                          i_ready;
   logic [LANES*DATA_WIDTH-1:0]   i_logits;
   logic                          o_valid;
   logic                          o_ready;
   logic [CLS_W-1:0]              o_class;
   logic signed [DATA_WIDTH-1:0]  o_max_logit;

   modport slave (
      input  i_valid, i_logits, o_ready,
      output i_ready, o_valid, o_class, o_max_logit
   );

   modport master (
      output i_valid, i_logits, o_ready,
      input  i_ready, o_valid, o_class, o_max_logit
   );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax over NUM_CLASSES signed logits delivered LANES per beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : argmax_stream_if.slave (input beats in, class/max result out)
// Each beat's lane maximum is merged into a running best; the last beat of a
// vector loads the output register. The lowest class index wins ties.
// Operating modes are implied by beat_cnt (IDLE/ACCUM) and o_valid (HOLD),
// which may overlap, so the state is held directly in those registers.
module argmax_stream #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned NUM_CLASSES = 12,
   parameter int unsigned LANES       = 4
) (
   input logic            clk,
   input logic            rst_n,
   argmax_stream_if.slave bus
);
   localparam int unsigned BEATS  = NUM_CLASSES / LANES;
   localparam int unsigned CLS_W  = ($clog2(NUM_CLASSES) > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [CNT_W-1:0]             beat_cnt,  beat_cnt_n;
   logic signed [DATA_WIDTH-1:0] best_val,  best_val_n;
   logic [CLS_W-1:0]             best_idx,  best_idx_n;
   logic                         valid_q,   valid_n;
   logic [CLS_W-1:0]             class_q,   class_n;
   logic signed [DATA_WIDTH-1:0] max_q,     max_n;

   logic                         last_beat;
   logic                         in_xfer;
   logic                         out_xfer;
   logic signed [DATA_WIDTH-1:0] lane_best_val;
   logic [LANE_W-1:0]            lane_best_idx;
   logic [CLS_W-1:0]             beat_best_idx;
   logic signed [DATA_WIDTH-1:0] merged_val;
   logic [CLS_W-1:0]             merged_idx;

   // Handshake qualifiers; the last beat only stalls on an undrained result.
   assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
   assign bus.i_ready = !(last_beat && valid_q && !bus.o_ready);
   assign in_xfer     = bus.i_valid && bus.i_ready;
   assign out_xfer    = valid_q && bus.o_ready;

   assign bus.o_valid     = valid_q;
   assign bus.o_class     = class_q;
   assign bus.o_max_logit = max_q;

   // Beat maximum; strict compare keeps the lowest lane on ties.
   always_comb begin
      lane_best_val = $signed(bus.i_logits[DATA_WIDTH-1:0]);
      lane_best_idx = '0;
      for (int unsigned k = 1; k < LANES; k++) begin
         if ($signed(bus.i_logits[k*DATA_WIDTH +: DATA_WIDTH]) > lane_best_val) begin
            lane_best_val = $signed(bus.i_logits[k*DATA_WIDTH +: DATA_WIDTH]);
            lane_best_idx = LANE_W'(k);
         end
      end
   end

   assign beat_best_idx = CLS_W'(beat_cnt) * CLS_W'(LANES) + CLS_W'(lane_best_idx);

   // Merge with running best; beat 0 loads unconditionally, later beats only
   // replace on strictly greater so earlier classes win ties.
   always_comb begin
      merged_val = best_val;
      merged_idx = best_idx;
      if ((beat_cnt == '0) || (lane_best_val > best_val)) begin
         merged_val = lane_best_val;
         merged_idx = beat_best_idx;
      end
   end

   // Next-state: beat counter, running best and output register.
   always_comb begin
      beat_cnt_n = beat_cnt;
      best_val_n = best_val;
      best_idx_n = best_idx;
      valid_n    = valid_q;
      class_n    = class_q;
      max_n      = max_q;
      if (out_xfer) begin
         valid_n = 1'b0;
      end
      if (in_xfer) begin
         beat_cnt_n = last_beat ? '0 : beat_cnt + CNT_W'(1);
         best_val_n = merged_val;
         best_idx_n = merged_idx;
         // A last beat coinciding with a drain reloads without a bubble.
         if (last_beat) begin
            valid_n = 1'b1;
            class_n = merged_idx;
            max_n   = merged_val;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         best_val <= '0;
         best_idx <= '0;
         valid_q  <= 1'b0;
         class_q  <= '0;
         max_q    <= '0;
      end else begin
         beat_cnt <= beat_cnt_n;
         best_val <= best_val_n;
         best_idx <= best_idx_n;
         valid_q  <= valid_n;
         class_q  <= class_n;
         max_q    <= max_n;
      end
   end
endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: default 16b/12 classes/4 lanes instance
// plus a degenerate 8b/3 classes/3 lanes instance.
module tb_argmax_stream;
   localparam int M = -32768;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   argmax_stream_if #(.DATA_WIDTH(16), .NUM_CLASSES(12), .LANES(4)) bus ();
   argmax_stream_if #(.DATA_WIDTH(8),  .NUM_CLASSES(3),  .LANES(3)) bus2 ();

   argmax_stream #(.DATA_WIDTH(16), .NUM_CLASSES(12), .LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   argmax_stream #(.DATA_WIDTH(8), .NUM_CLASSES(3), .LANES(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2));

   typedef struct {
      logic [3:0]         cls;
      logic signed [15:0] val;
   } exp_t;

   typedef struct {
      logic [1:0]        cls;
      logic signed [7:0] val;
   } exp2_t;

   exp_t  q[$];
   exp2_t q2[$];
   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit btb = 1'b0;
   bit have_last = 1'b0;
   int last_cycle = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic push(input int c, input int v);
      exp_t e;
      e.cls = 4'(c);
      e.val = 16'(v);
      q.push_back(e);
   endtask

   task automatic push2(input int c, input int v);
      exp2_t e;
      e.cls = 2'(c);
      e.val = 8'(v);
      q2.push_back(e);
   endtask

   // Monitor for the main instance.
   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.o_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual_class=%0d required=none", bus.o_class);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("o_class", {28'b0, bus.o_class}, {28'b0, e.cls});
            check("o_max_logit", $signed(bus.o_max_logit), e.val);
            if (btb && have_last) check("btb_spacing", cycle - last_cycle, 3);
            last_cycle = cycle;
            have_last  = 1'b1;
         end
      end
      if (btb) check("btb_i_ready", {31'b0, bus.i_ready}, 1);
   end

   // Monitor for the degenerate instance.
   always @(negedge clk) begin
      if (rst_n && bus2.o_valid && bus2.o_ready) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result2 actual_class=%0d required=none", bus2.o_class);
         end else begin
            exp2_t e;
            e = q2.pop_front();
            check("o_class2", {30'b0, bus2.o_class}, {30'b0, e.cls});
            check("o_max_logit2", $signed(bus2.o_max_logit), e.val);
         end
      end
   end

   // One beat transfer; leaves i_valid high so beats can run back to back.
   task automatic send_beat(input logic [63:0] v, output int waited);
      bit done;
      done = 1'b0;
      waited = 0;
      bus.i_valid  = 1'b1;
      bus.i_logits = v;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = bus.i_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_beat_timeout actual=stalled required=accepted");
      end
   endtask

   task automatic send_vec(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2);
      int w;
      send_beat(b0, w);
      send_beat(b1, w);
      send_beat(b2, w);
      bus.i_valid = 1'b0;
   endtask

   task automatic send2(input int a, input int b, input int c);
      bus2.i_valid  = 1'b1;
      bus2.i_logits = {8'(c), 8'(b), 8'(a)};
      @(negedge clk);
      check("deg_i_ready", {31'b0, bus2.i_ready}, 1);
      check("deg_valid_before", {31'b0, bus2.o_valid}, 0);
      @(posedge clk);
      #1;
      bus2.i_valid = 1'b0;
      @(negedge clk);
      check("deg_latency_valid", {31'b0, bus2.o_valid}, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      bus.i_valid   = 1'b0;
      bus.i_logits  = '0;
      bus.o_ready   = 1'b1;
      bus2.i_valid  = 1'b0;
      bus2.i_logits = '0;
      bus2.o_ready  = 1'b1;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst_o_valid", {31'b0, bus.o_valid}, 0);
      check("rst_i_ready", {31'b0, bus.i_ready}, 1);
      check("rst_o_class", {28'b0, bus.o_class}, 0);
      check("rst_o_max", $signed(bus.o_max_logit), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic vector, 1-cycle latency, valid clears after transfer
      push(5, 90);
      send_vec(pk(1, 2, 3, 4), pk(5, 90, 7, 8), pk(9, 10, 11, 12));
      @(negedge clk);
      check("basic_latency_valid", {31'b0, bus.o_valid}, 1);
      @(negedge clk);
      check("basic_valid_clear", {31'b0, bus.o_valid}, 0);
      @(posedge clk);
      #1;

      // Negatives and ties
      push(6, -3);
      send_vec(pk(M, M, M, M), pk(M, M, -3, M), pk(M, -3, M, M));
      push(0, 7);
      send_vec(pk(7, 7, 7, 7), pk(7, 7, 7, 7), pk(7, 7, 7, 7));
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: result 2 held, next vector's beats 0-1 accepted, last stalls
      bus.o_ready = 1'b0;
      push(2, 50);
      send_vec(pk(0, 0, 50, 0), pk(1, 1, 1, 1), pk(1, 1, 1, 1));
      push(11, 20);
      send_beat(pk(-1, -1, -1, -1), w);
      check("bp_beat0_no_stall", w, 1);
      send_beat(pk(-1, -1, -1, -1), w);
      check("bp_beat1_no_stall", w, 1);
      bus.i_logits = pk(-1, -1, -1, 20);
      repeat (3) begin
         @(negedge clk);
         check("bp_last_i_ready", {31'b0, bus.i_ready}, 0);
         check("bp_hold_valid", {31'b0, bus.o_valid}, 1);
         check("bp_hold_class", {28'b0, bus.o_class}, 2);
         check("bp_hold_max", $signed(bus.o_max_logit), 50);
      end
      @(posedge clk);
      #1;
      bus.o_ready = 1'b1;
      send_beat(pk(-1, -1, -1, 20), w);
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("bp_no_bubble_valid", {31'b0, bus.o_valid}, 1);
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back, five vectors
      have_last = 1'b0;
      btb = 1'b1;
      push(5, 90);
      push(6, -3);
      push(0, 7);
      push(0, M);
      push(8, 32767);
      send_vec(pk(1, 2, 3, 4), pk(5, 90, 7, 8), pk(9, 10, 11, 12));
      send_vec(pk(M, M, M, M), pk(M, M, -3, M), pk(M, -3, M, M));
      send_vec(pk(7, 7, 7, 7), pk(7, 7, 7, 7), pk(7, 7, 7, 7));
      send_vec(pk(M, M, M, M), pk(M, M, M, M), pk(M, M, M, M));
      send_vec(pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(32767, 0, 0, 0));
      @(negedge clk);
      @(negedge clk);
      btb = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-vector while a result is held: both are discarded
      bus.o_ready = 1'b0;
      send_vec(pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(9, 10, 11, 100));
      send_beat(pk(1000, 0, 0, 0), w);
      send_beat(pk(0, 0, 0, 0), w);
      bus.i_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_o_valid", {31'b0, bus.o_valid}, 0);
      check("midrst_i_ready", {31'b0, bus.i_ready}, 1);
      check("midrst_o_class", {28'b0, bus.o_class}, 0);
      check("midrst_o_max", $signed(bus.o_max_logit), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.o_ready = 1'b1;
      push(5, 90);
      send_vec(pk(1, 2, 3, 4), pk(5, 90, 7, 8), pk(9, 10, 11, 12));
      repeat (2) @(posedge clk);
      #1;

      // Degenerate single-beat configuration
      push2(2, -4);
      send2(-5, -5, -4);
      push2(0, -5);
      send2(-5, -5, -5);
      push2(0, 127);
      send2(127, -128, 127);

      for (int n = 0; n < 50 && (q.size() + q2.size()) != 0; n++) @(posedge clk);
      #1;
      check("queues_drained", q.size() + q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of each signed two's-complement logit.
REQ-002 The block SHALL have parameter NUM_CLASSES, default 12, meaning the number of logits per vector; legal range is 2 or more.
REQ-003 The block SHALL have parameter LANES, default 4, meaning the number of logits carried per input beat; NUM_CLASSES SHALL be an integer multiple of LANES.
REQ-004 The block SHALL derive localparam BEATS = NUM_CLASSES/LANES.
REQ-005 The block SHALL derive localparam CLS_W = max(1, clog2(NUM_CLASSES)).
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port i_valid, input, 1 bit: i_logits holds a valid beat.
REQ-009 Port i_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-010 Port i_logits, input, LANES*DATA_WIDTH bits: lane k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; class index = beat_index*LANES + k.
REQ-011 Port o_valid, output, 1 bit: a result is held on the outputs.
REQ-012 Port o_ready, input, 1 bit: the downstream block accepts the result.
REQ-013 Port o_class, output, CLS_W bits: index of the maximum logit.
REQ-014 Port o_max_logit, output, DATA_WIDTH bits, signed: value of the maximum logit.

Function
REQ-015 A beat SHALL transfer in any cycle with i_valid=1 and i_ready=1; an output transfer SHALL occur in any cycle with o_valid=1 and o_ready=1.
REQ-016 Beats SHALL be counted by beat_cnt, range 0..BEATS-1; the beat with beat_cnt=BEATS-1 is the last beat of a vector.
  - beat_cnt SHALL increment on each input transfer.
  - beat_cnt SHALL wrap from BEATS-1 to 0 on the last-beat transfer.
  - When BEATS=1, every beat is a last beat.
REQ-017 Per beat, the block SHALL find the maximum of the LANES logits combinationally, using signed comparison, ties resolved to the lowest lane.
REQ-018 The beat winner SHALL be merged into the running best (best_val, best_idx):
  - On beat 0, the running best SHALL be loaded unconditionally.
  - On later beats, it SHALL be replaced only if the beat winner is strictly greater than best_val.
  - The overall tie rule is therefore: the lowest class index wins.
REQ-019 On the last-beat transfer, the merged result SHALL be written to o_class and o_max_logit, and o_valid SHALL be set on the next edge.
  - Latency from the last-beat transfer to o_valid=1 is 1 cycle.
REQ-020 The outputs SHALL remain stable while o_valid=1 and o_ready=0.
REQ-021 On an output transfer with no simultaneous last-beat transfer, o_valid SHALL clear on the next edge.
REQ-022 i_ready SHALL equal NOT(beat_cnt==BEATS-1 AND o_valid AND NOT o_ready).
  - Non-last beats of the next vector SHALL be accepted while a result is pending.
  - The last beat SHALL stall only while the output register is occupied and not draining.
REQ-023 A simultaneous output transfer and last-beat transfer SHALL load the new result, keep o_valid=1, and cause no bubble and no loss.
REQ-024 Operating states:
  - IDLE: beat_cnt=0, o_valid=0.
  - ACCUM: beat_cnt>0.
  - HOLD: o_valid=1.
  - ACCUM and HOLD MAY coexist.
  - State transitions are exactly those implied by REQ-016 to REQ-023.
REQ-025 Comparison SHALL use full DATA_WIDTH signed arithmetic; no truncation and no saturation; the most-negative value SHALL be handled correctly.
REQ-026 i_logits SHALL be ignored in cycles where no input transfer occurs; changing it while i_ready=0 SHALL not affect state.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force all of the following, independent of clk:
  - o_valid=0, o_class=0, o_max_logit=0.
  - beat_cnt=0, best_val=0, best_idx=0.
  - i_ready=1, by REQ-022.
REQ-028 Assertion of rst_n mid-vector SHALL discard the partial vector; the first beat after release SHALL be treated as beat 0.
REQ-029 Assertion of rst_n while o_valid=1 SHALL drop the held result without an output transfer.

Verification (DATA_WIDTH=16, NUM_CLASSES=12, LANES=4 unless stated)
REQ-030 Basic: beats {1,2,3,4},{5,90,7,8},{9,10,11,12}, o_ready=1 -> o_valid=1 one cycle after beat 3; o_class=5; o_max_logit=90.
REQ-031 Ties and negatives: all logits -32768 except classes 6 and 9 = -3 -> o_class=6, o_max_logit=-3; all 12 logits equal 7 -> o_class=0.
REQ-032 Backpressure: o_ready=0 through two full vectors (max at 2, then at 11) ->
  - Result 2 is held stable.
  - The second vector's beats 0-1 are accepted.
  - i_ready=0 on its last beat.
  - Raising o_ready -> result 2 transfers, then result 11 follows with no loss.
REQ-033 Back-to-back: continuous i_valid=1 and o_ready=1 over 5 vectors -> one result every 3 cycles, with no stall and no bubble.
REQ-034 Reset mid-vector: rst_n pulsed low after beat 1 -> o_valid=0 immediately; the next 3 beats form a fresh vector whose result is correct.
REQ-035 Degenerate: NUM_CLASSES=3, LANES=3, DATA_WIDTH=8, logits {-5,-5,-4} -> o_class=2, o_max_logit=-4, 1-cycle latency.
